// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-op encodings, mem_stage FSM states,
// CPSR bit positions and a small op-decoding helper.
package cpu_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    localparam int CPSR_N = 3;
    localparam int CPSR_C = 2;
    localparam int CPSR_Z = 1;
    localparam int CPSR_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } state_t;

    // The reserved encoding 2'b11 is deliberately not a memory op.
    function automatic logic is_mem_op(logic [1:0] op);
        return (op == MEM_LOAD) || (op == MEM_STORE);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of execute-side, data-memory and write-back signals of mem_stage.
// slave: the memory stage itself; master: its surroundings.
interface mem_stage_if;

    logic        ex_valid;
    logic        ex_ready;
    logic [32:0] ex_result;
    logic        ex_w_enable;
    logic [2:0]  ex_dest_reg;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_store_data;
    logic        ex_set_flags;
    logic [3:0]  ex_flags;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    logic        wb_valid;
    logic        wb_w_enable;
    logic [2:0]  wb_dest_reg;
    logic [31:0] wb_data;

    logic [3:0]  cpsr;
    logic        mem_fault;

    modport slave (
        input  ex_valid, ex_result, ex_w_enable, ex_dest_reg, ex_mem_op,
               ex_store_data, ex_set_flags, ex_flags, dmem_ack, dmem_rdata,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               wb_valid, wb_w_enable, wb_dest_reg, wb_data, cpsr, mem_fault
    );

    modport master (
        output ex_valid, ex_result, ex_w_enable, ex_dest_reg, ex_mem_op,
               ex_store_data, ex_set_flags, ex_flags, dmem_ack, dmem_rdata,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               wb_valid, wb_w_enable, wb_dest_reg, wb_data, cpsr, mem_fault
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Request-cycle counter for the data-memory timeout. hit is high during the
// LIMIT-th enabled cycle since the last clear.
module mem_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    assign hit = en && (cnt == W'(LIMIT - 1));

    // Count enabled cycles; hold at the limit so the counter never wraps.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !hit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: optional word load/store, write-back record,
// CPSR ownership. Define MEM_TIMEOUT_EN to abort requests that stay
// unacknowledged for TIMEOUT_CYCLES cycles and raise the sticky mem_fault.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready to accept an instruction from execute
// ST_ACCESS | dmem request outstanding, waiting for ack (or timeout)
// ST_WB     | write-back record presented for exactly one cycle
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.slave   bus
);

    import cpu_pkg::*;

    state_t     state;
    logic [1:0] cap_op;
    logic [2:0] cap_dest;
    logic       accept;
    logic       timeout_hit;
    logic       carry_unused;

    assign accept       = bus.ex_valid && bus.ex_ready;
    assign carry_unused = bus.ex_result[32];

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (state == ST_ACCESS),
        .hit (timeout_hit)
    );
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // Stage FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            cap_op          <= MEM_NONE;
            cap_dest        <= '0;
            bus.ex_ready    <= 1'b1;
            bus.dmem_req    <= 1'b0;
            bus.dmem_we     <= 1'b0;
            bus.dmem_addr   <= '0;
            bus.dmem_wdata  <= '0;
            bus.wb_valid    <= 1'b0;
            bus.wb_w_enable <= 1'b0;
            bus.wb_dest_reg <= '0;
            bus.wb_data     <= '0;
            bus.cpsr        <= '0;
            bus.mem_fault   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bus.ex_ready <= 1'b0;
                        cap_op       <= bus.ex_mem_op;
                        cap_dest     <= bus.ex_dest_reg;
                        if (bus.ex_set_flags) begin
                            bus.cpsr[CPSR_N] <= bus.ex_flags[CPSR_N];
                            bus.cpsr[CPSR_C] <= bus.ex_flags[CPSR_C];
                            bus.cpsr[CPSR_Z] <= bus.ex_flags[CPSR_Z];
                            bus.cpsr[CPSR_V] <= bus.ex_flags[CPSR_V];
                        end
                        if (is_mem_op(bus.ex_mem_op)) begin
                            state          <= ST_ACCESS;
                            bus.dmem_req   <= 1'b1;
                            bus.dmem_we    <= (bus.ex_mem_op == MEM_STORE);
                            bus.dmem_addr  <= bus.ex_result[31:0];
                            bus.dmem_wdata <= bus.ex_store_data;
                        end else begin
                            state           <= ST_WB;
                            bus.wb_valid    <= 1'b1;
                            bus.wb_w_enable <= bus.ex_w_enable;
                            bus.wb_dest_reg <= bus.ex_dest_reg;
                            bus.wb_data     <= bus.ex_result[31:0];
                        end
                    end
                end

                ST_ACCESS: begin
                    // An ack on the limit cycle takes priority over the timeout.
                    if (bus.dmem_ack || timeout_hit) begin
                        state           <= ST_WB;
                        bus.dmem_req    <= 1'b0;
                        bus.dmem_we     <= 1'b0;
                        bus.dmem_addr   <= '0;
                        bus.dmem_wdata  <= '0;
                        bus.wb_valid    <= 1'b1;
                        bus.wb_dest_reg <= cap_dest;
                        if (bus.dmem_ack && (cap_op == MEM_LOAD)) begin
                            bus.wb_w_enable <= 1'b1;
                            bus.wb_data     <= bus.dmem_rdata;
                        end else begin
                            bus.wb_w_enable <= 1'b0;
                            bus.wb_data     <= '0;
                        end
                        if (!bus.dmem_ack) begin
                            bus.mem_fault <= 1'b1;
                        end
                    end
                end

                ST_WB: begin
                    state           <= ST_IDLE;
                    bus.ex_ready    <= 1'b1;
                    bus.wb_valid    <= 1'b0;
                    bus.wb_w_enable <= 1'b0;
                    bus.wb_dest_reg <= '0;
                    bus.wb_data     <= '0;
                end

                default: begin
                    state        <= ST_IDLE;
                    bus.ex_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage. Timeout vectors run only when the
// design is built with MEM_TIMEOUT_EN.
module tb_mem_stage;

    import cpu_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    mem_stage_if bus ();

    mem_stage #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [32:0] res, input logic wen,
                           input logic [2:0] dest, input logic [31:0] sdata,
                           input logic setf, input logic [3:0] flags);
        bus.ex_valid      = 1'b1;
        bus.ex_mem_op     = op;
        bus.ex_result     = res;
        bus.ex_w_enable   = wen;
        bus.ex_dest_reg   = dest;
        bus.ex_store_data = sdata;
        bus.ex_set_flags  = setf;
        bus.ex_flags      = flags;
        tick();
        bus.ex_valid      = 1'b0;
        bus.ex_set_flags  = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst = 1'b1;
        bus.ex_valid = 1'b0; bus.ex_result = '0; bus.ex_w_enable = 1'b0;
        bus.ex_dest_reg = '0; bus.ex_mem_op = MEM_NONE; bus.ex_store_data = '0;
        bus.ex_set_flags = 1'b0; bus.ex_flags = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
        chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_dmem_addr", bus.dmem_addr, 32'h0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'h0);
        chk("rst_cpsr", 32'(bus.cpsr), 32'h0);
        chk("rst_fault", 32'(bus.mem_fault), 32'd0);

        // stray ack while idle is ignored
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1357_9BDF;
        tick();
        bus.dmem_ack = 1'b0;
        chk("idle_ack_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("idle_ack_ready", 32'(bus.ex_ready), 32'd1);

        // non-memory op
        present(MEM_NONE, 33'h0_0000_1234, 1'b1, 3'd3, 32'h0, 1'b0, 4'h0);
        chk("alu_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("alu_wb_data", bus.wb_data, 32'h1234);
        chk("alu_wb_dest", 32'(bus.wb_dest_reg), 32'd3);
        chk("alu_wb_wen", 32'(bus.wb_w_enable), 32'd1);
        chk("alu_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("alu_ready_in_wb", 32'(bus.ex_ready), 32'd0);
        tick();
        chk("alu_wb_drop", 32'(bus.wb_valid), 32'd0);
        chk("alu_wb_data_zero", bus.wb_data, 32'h0);
        chk("alu_ready_back", 32'(bus.ex_ready), 32'd1);
        chk("alu_dmem_req2", 32'(bus.dmem_req), 32'd0);

        // load, ack in the 3rd request cycle
        present(MEM_LOAD, 33'h0_0000_0040, 1'b0, 3'd5, 32'h0, 1'b0, 4'h0);
        chk("ld_req_c1", 32'(bus.dmem_req), 32'd1);
        chk("ld_we", 32'(bus.dmem_we), 32'd0);
        chk("ld_addr_c1", bus.dmem_addr, 32'h40);
        chk("ld_ready", 32'(bus.ex_ready), 32'd0);
        tick();
        chk("ld_req_c2", 32'(bus.dmem_req), 32'd1);
        chk("ld_wb_c2", 32'(bus.wb_valid), 32'd0);
        tick();
        chk("ld_req_c3", 32'(bus.dmem_req), 32'd1);
        chk("ld_addr_c3", bus.dmem_addr, 32'h40);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        chk("ld_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("ld_wb_data", bus.wb_data, 32'hDEAD_BEEF);
        chk("ld_wb_wen", 32'(bus.wb_w_enable), 32'd1);
        chk("ld_wb_dest", 32'(bus.wb_dest_reg), 32'd5);
        chk("ld_req_drop", 32'(bus.dmem_req), 32'd0);
        tick();
        chk("ld_wb_end", 32'(bus.wb_valid), 32'd0);
        chk("ld_ready_back", 32'(bus.ex_ready), 32'd1);

        // store, ack in the first request cycle
        present(MEM_STORE, 33'h0_0000_0080, 1'b1, 3'd2, 32'hA5A5_A5A5, 1'b0, 4'h0);
        chk("st_req", 32'(bus.dmem_req), 32'd1);
        chk("st_we", 32'(bus.dmem_we), 32'd1);
        chk("st_addr", bus.dmem_addr, 32'h80);
        chk("st_wdata", bus.dmem_wdata, 32'hA5A5_A5A5);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_0000;
        tick();
        bus.dmem_ack = 1'b0;
        chk("st_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("st_wb_wen", 32'(bus.wb_w_enable), 32'd0);
        chk("st_wb_data", bus.wb_data, 32'h0);
        chk("st_wb_dest", 32'(bus.wb_dest_reg), 32'd2);
        chk("st_req_drop", 32'(bus.dmem_req), 32'd0);
        tick();
        chk("st_ready_back", 32'(bus.ex_ready), 32'd1);

        // flag update, carry bit of the result does not reach wb_data
        present(MEM_NONE, 33'h1_0000_0007, 1'b1, 3'd1, 32'h0, 1'b1, 4'b1010);
        chk("fl_cpsr_set", 32'(bus.cpsr), 32'b1010);
        chk("fl_wb_data", bus.wb_data, 32'h7);
        tick();
        // reserved op behaves as non-memory; flags not selected so cpsr holds
        present(2'b11, 33'h0_0000_0055, 1'b0, 3'd6, 32'h0, 1'b0, 4'b0101);
        chk("fl_cpsr_hold", 32'(bus.cpsr), 32'b1010);
        chk("rsv_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("rsv_wb_data", bus.wb_data, 32'h55);
        chk("rsv_wb_wen", 32'(bus.wb_w_enable), 32'd0);
        chk("rsv_dmem_req", 32'(bus.dmem_req), 32'd0);
        tick();
        chk("fl_cpsr_hold2", 32'(bus.cpsr), 32'b1010);

        // store does not touch cpsr
        present(MEM_STORE, 33'h0_0000_0010, 1'b0, 3'd0, 32'h1, 1'b0, 4'b1111);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        chk("st_cpsr_hold", 32'(bus.cpsr), 32'b1010);
        tick();

        // reset in the 2nd ACCESS cycle, then a late ack
        present(MEM_LOAD, 33'h0_0000_0100, 1'b0, 3'd4, 32'h0, 1'b0, 4'h0);
        tick();
        chk("ra_req_c2", 32'(bus.dmem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1111_1111;
        chk("ra_req_off", 32'(bus.dmem_req), 32'd0);
        chk("ra_ready", 32'(bus.ex_ready), 32'd1);
        chk("ra_cpsr", 32'(bus.cpsr), 32'h0);
        chk("ra_wb_valid", 32'(bus.wb_valid), 32'd0);
        tick();
        bus.dmem_ack = 1'b0;
        chk("ra_late_ack_wb", 32'(bus.wb_valid), 32'd0);
        chk("ra_late_ack_req", 32'(bus.dmem_req), 32'd0);
        chk("ra_fault", 32'(bus.mem_fault), 32'd0);

`ifdef MEM_TIMEOUT_EN
        // ack on the limit cycle wins
        present(MEM_LOAD, 33'h0_0000_0200, 1'b0, 3'd7, 32'h0, 1'b0, 4'h0);
        tick(); tick(); tick();
        chk("tw_req_c4", 32'(bus.dmem_req), 32'd1);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0000_0077;
        tick();
        bus.dmem_ack = 1'b0;
        chk("tw_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("tw_wb_wen", 32'(bus.wb_w_enable), 32'd1);
        chk("tw_wb_data", bus.wb_data, 32'h77);
        chk("tw_fault", 32'(bus.mem_fault), 32'd0);
        tick();

        // load never acked: aborts after 4 request cycles
        present(MEM_LOAD, 33'h0_0000_0300, 1'b0, 3'd2, 32'h0, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            chk("to_req", 32'(bus.dmem_req), 32'd1);
            chk("to_wb_wait", 32'(bus.wb_valid), 32'd0);
            chk("to_fault_wait", 32'(bus.mem_fault), 32'd0);
            tick();
        end
        chk("to_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("to_wb_wen", 32'(bus.wb_w_enable), 32'd0);
        chk("to_fault", 32'(bus.mem_fault), 32'd1);
        chk("to_req_drop", 32'(bus.dmem_req), 32'd0);
        tick();
        chk("to_wb_end", 32'(bus.wb_valid), 32'd0);
        chk("to_fault_sticky", 32'(bus.mem_fault), 32'd1);
        tick();
        chk("to_fault_sticky2", 32'(bus.mem_fault), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_fault_clr", 32'(bus.mem_fault), 32'd0);
`else
        // without the timeout the request waits indefinitely
        present(MEM_LOAD, 33'h0_0000_0300, 1'b0, 3'd2, 32'h0, 1'b0, 4'h0);
        for (int i = 0; i < 20; i++) tick();
        chk("nt_req_hold", 32'(bus.dmem_req), 32'd1);
        chk("nt_wb_idle", 32'(bus.wb_valid), 32'd0);
        chk("nt_fault", 32'(bus.mem_fault), 32'd0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
        tick();
        bus.dmem_ack = 1'b0;
        chk("nt_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("nt_wb_data", bus.wb_data, 32'hCAFE_F00D);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipeline, directly downstream of the execute stage. Accepts one executed instruction per handshake and performs the optional word load or store on the data-memory port. Forwards the write-back record (destination register, data, write enable) to the register file and owns the architectural CPSR flag register (N, C, Z, V).

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: cycles `dmem_req` may stay unacknowledged before abort. Only used with `MEM_TIMEOUT_EN`.

Ports:
- `clk` — in, 1: single clock, rising edge.
- `rst` — in, 1: reset. Synchronous, active-high.
- `ex_valid` — in, 1: execute stage presents an instruction.
- `ex_ready` — out, 1: stage can accept. High only in IDLE.
- `ex_result` — in, 33: ALU result. Bit 32 is carry. Bits 31:0 are the data or memory address.
- `ex_w_enable` — in, 1: instruction writes a register.
- `ex_dest_reg` — in, 3: destination register.
- `ex_mem_op` — in, 2: 00 none, 01 load, 10 store, 11 reserved (treated as none).
- `ex_store_data` — in, 32: store data.
- `ex_set_flags` — in, 1: update CPSR from `ex_flags`.
- `ex_flags` — in, 4: N, C, Z, V (bit 3..0).
- `dmem_req` — out, 1: memory request.
- `dmem_we` — out, 1: request is a write.
- `dmem_addr` — out, 32: word address.
- `dmem_wdata` — out, 32: write data.
- `dmem_ack` — in, 1: request completed. `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` — in, 32: read data.
- `wb_valid` — out, 1: one-cycle pulse, write-back record valid.
- `wb_w_enable` — out, 1: register write.
- `wb_dest_reg` — out, 3: register index.
- `wb_data` — out, 32: write data.
- `cpsr` — out, 4: current N, C, Z, V.
- `mem_fault` — out, 1: sticky timeout fault.

## Operation
- The instruction is accepted on a `clk` edge with `ex_valid && ex_ready`. All fields are captured into internal registers at that edge.
- FSM states:
  - IDLE
    - On accept with mem_op none → WB.
    - On accept with load or store → ACCESS.
  - ACCESS
    - Drive `dmem_req`=1. `dmem_addr`=captured `ex_result[31:0]`, `dmem_we`=(op==store), `dmem_wdata`=captured store data.
    - On `dmem_ack` → WB. For a load, `dmem_rdata` is latched as write-back data.
  - WB
    - `wb_valid`=1 for exactly one cycle, then → IDLE.
- Write-back rules:
  - Non-memory: `wb_data`=`ex_result[31:0]`, `wb_w_enable`=`ex_w_enable`.
  - Load: `wb_data`=read data, `wb_w_enable`=1.
  - Store: `wb_w_enable`=0, `wb_data`=0.
- CPSR: on accept with `ex_set_flags`=1, `cpsr` <= `ex_flags` at the accept edge. Otherwise it holds. It is never modified by memory ops.
- `dmem_ack` outside ACCESS is ignored.
- `wb_*` outputs are 0 whenever `wb_valid`=0.

## Timing
- Reset values: state IDLE, `ex_ready`=1, `dmem_req`/`dmem_we`=0, `dmem_addr`/`dmem_wdata`=0, `wb_valid`/`wb_w_enable`=0, `wb_dest_reg`=0, `wb_data`=0, `cpsr`=0000, `mem_fault`=0.
- Non-memory op: accept at edge T; `wb_valid` high in cycle T+1; `ex_ready` high again at T+2.
- Memory op: `dmem_req` high from T+1. If ack is sampled at edge T+k, `wb_valid` is high in cycle T+k+1. Minimum latency is 2 cycles (ack in the first request cycle).
- `dmem_req` and all `dmem_*` outputs are stable until the ack edge. `dmem_req` drops in the cycle after ack.
- Throughput: one instruction per 2 cycles minimum. There is no accept during WB.
- Reset asserted mid-ACCESS: `dmem_req` is 0 in the cycle after the reset edge and the transaction is abandoned. A late ack is ignored.
- Reset during WB: the pending write-back is suppressed.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An up-counter runs in ACCESS. It is cleared on entry to ACCESS.
  - After `TIMEOUT_CYCLES` request cycles without ack: → WB with `wb_w_enable`=0, and `mem_fault` is set. `mem_fault` is cleared only by `rst`.
  - An ack on the same edge the limit is reached wins: normal completion, no fault.
- Not defined: no counter; ACCESS waits indefinitely; `mem_fault` is tied to 0.

## Structure
- The shared package `cpu_pkg` holds:
  - mem_op encodings (`MEM_NONE`, `MEM_LOAD`, `MEM_STORE`);
  - the FSM state enum (IDLE, ACCESS, WB);
  - CPSR bit-index constants (N=3, C=2, Z=1, V=0).
- One sub-module, `mem_timeout_ctr`: clear, enable, limit-reached output. It is instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- ALU result 0x0000_1234, `ex_w_enable`=1, dest 3 → `wb_valid` one cycle after accept with `wb_data`=0x1234, `wb_dest_reg`=3. `dmem_req` never asserts.
- Load at address 0x40; ack after 3 request cycles with rdata 0xDEAD_BEEF → `dmem_we`=0, `wb_data`=0xDEADBEEF, `wb_w_enable`=1, total latency 4 cycles.
- Store 0xA5A5_A5A5 to 0x80; ack in the first request cycle → `dmem_we`=1, `dmem_wdata`=0xA5A5A5A5, then `wb_valid` with `wb_w_enable`=0.
- `ex_set_flags`=1, `ex_flags`=1010, then an op with `ex_set_flags`=0 → `cpsr`=1010 from the first accept onward and held through the second.
- Reset asserted in the 2nd ACCESS cycle, then ack pulsed → `dmem_req`=0 next cycle, no `wb_valid`, `cpsr`=0000, `ex_ready`=1.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, load never acked → after 4 request cycles `wb_valid` pulses with `wb_w_enable`=0 and `mem_fault`=1 until `rst`.
